// File: rtl/tpu_pkg.sv
// Shared types for the accumulator file.
// Holds the lane word type, the row address type, the clear FSM state
// enum and the control fields of a write request.
package tpu_pkg;

    localparam int unsigned BYTE_WIDTH     = 8;
    localparam int unsigned WORD_WIDTH     = 4 * BYTE_WIDTH;
    localparam int unsigned ACC_ADDR_WIDTH = 10;

    typedef logic [WORD_WIDTH-1:0]     word_type;
    typedef logic [ACC_ADDR_WIDTH-1:0] accumulator_addr_type;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } acc_fsm_state_type;

    // Control half of an in-flight write; lane data travels alongside.
    typedef struct packed {
        logic                 valid;
        accumulator_addr_type addr;
        logic                 accumulate;
        logic                 saturate;
    } acc_req_type;

endpackage

// File: rtl/acc_sat_adder.sv
// One lane of the accumulator adder: unsigned 32-bit add that either wraps
// or clamps to all-ones on carry-out.
// Ports: a, b      - operands
//        saturate  - 1 clamps on overflow, 0 wraps
//        sum_c     - combinational result
module acc_sat_adder
    import tpu_pkg::*;
(
    input  word_type a,
    input  word_type b,
    input  logic     saturate,
    output word_type sum_c
);

    logic [WORD_WIDTH:0] full_c;

    assign full_c = {1'b0, a} + {1'b0, b};
    assign sum_c  = (saturate && full_c[WORD_WIDTH]) ? '1 : full_c[WORD_WIDTH-1:0];

endmodule

// File: rtl/accumulator_file.sv
// Row-addressed accumulator memory with overwrite / accumulate writes, a
// 3-edge write pipeline with forwarding, a 2-edge read path and a
// drain-then-clear sequencer.
// Ports: clk, rst (sync, active high), enable (global advance)
//        write_addr, data_in, write_enable, accumulate, saturate - write request
//        read_addr, data_out                                     - read port
//        clear_start, busy                                       - bulk clear
//        write_dropped - one-cycle pulse for a discarded write
module accumulator_file
    import tpu_pkg::*;
#(
    parameter int unsigned MATRIX_WIDTH     = 14,
    parameter int unsigned REGISTER_DEPTH   = 512,
    parameter bit          SATURATE_DEFAULT = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  accumulator_addr_type             write_addr,
    input  word_type [MATRIX_WIDTH-1:0]      data_in,
    input  logic                             write_enable,
    input  logic                             accumulate,
    input  logic                             saturate,
    input  accumulator_addr_type             read_addr,
    output word_type [MATRIX_WIDTH-1:0]      data_out,
    input  logic                             clear_start,
    output logic                             busy,
    output logic                             write_dropped
);

    localparam int unsigned ROW_W = (REGISTER_DEPTH > 1) ? $clog2(REGISTER_DEPTH) : 1;
    localparam acc_req_type REQ_RST = '{valid: 1'b0, addr: '0, accumulate: 1'b0,
                                        saturate: SATURATE_DEFAULT};

    typedef word_type [MATRIX_WIDTH-1:0] row_type;

    acc_fsm_state_type    state_q, state_d;
    logic [1:0]           drain_cnt_q, drain_cnt_d;
    logic [ROW_W-1:0]     clr_cnt_q, clr_cnt_d;
    logic                 clr_we_c;

    acc_req_type          p1_q, p2_q;
    logic                 p3_valid_q, p4_valid_q;
    accumulator_addr_type p3_addr_q, p4_addr_q;
    row_type              p1_data_q, p2_data_q, p3_data_q, p4_data_q;
    row_type              mem_acc_q;
    row_type              old_c, sum_c, result_c;

    logic [ROW_W-1:0]     rd_addr_q;
    logic                 rd_ok_q, rd_ok2_q;
    row_type              rd_data_q;

    logic                 wr_accept_c, wr_drop_c;

    row_type              mem [REGISTER_DEPTH];

    // Write admission: only in IDLE and only for rows that exist.
    assign wr_accept_c = write_enable && (state_q == IDLE) &&
                         (32'(write_addr) < REGISTER_DEPTH);
    assign wr_drop_c   = write_enable && !wr_accept_c;

    // Clear sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            clr_cnt_q   <= '0;
            busy        <= 1'b0;
        end else if (enable) begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            clr_cnt_q   <= clr_cnt_d;
            busy        <= (state_d != IDLE);
        end
    end

    // Clear sequencer next state: drain three cycles, then zero every row.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        clr_cnt_d   = clr_cnt_q;
        clr_we_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == 2'd2) begin
                    state_d     = CLEAR;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            CLEAR: begin
                clr_we_c = 1'b1;
                if (clr_cnt_q == ROW_W'(REGISTER_DEPTH - 1)) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ROW_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write pipeline control: p1 sampled, p2 has old row, p3 awaiting commit,
    // p4 remembers the row committed on the edge p2's memory read used.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_q       <= REQ_RST;
            p2_q       <= REQ_RST;
            p3_valid_q <= 1'b0;
            p3_addr_q  <= '0;
            p4_valid_q <= 1'b0;
            p4_addr_q  <= '0;
        end else if (enable) begin
            p1_q       <= '{valid: wr_accept_c, addr: write_addr,
                            accumulate: accumulate, saturate: saturate};
            p2_q       <= p1_q;
            p3_valid_q <= p2_q.valid;
            p3_addr_q  <= p2_q.addr;
            p4_valid_q <= p3_valid_q;
            p4_addr_q  <= p3_addr_q;
        end
    end

    // Write pipeline data.
    always_ff @(posedge clk) begin
        if (enable) begin
            p1_data_q <= data_in;
            p2_data_q <= p1_data_q;
            p3_data_q <= result_c;
            p4_data_q <= p3_data_q;
        end
    end

    // Youngest matching in-flight write wins over the memory's old data.
    always_comb begin
        old_c = mem_acc_q;
        if (p4_valid_q && (p4_addr_q == p2_q.addr)) begin
            old_c = p4_data_q;
        end
        if (p3_valid_q && (p3_addr_q == p2_q.addr)) begin
            old_c = p3_data_q;
        end
    end

    for (genvar l = 0; l < MATRIX_WIDTH; l++) begin : g_lane
        acc_sat_adder u_add (
            .a        (old_c[l]),
            .b        (p2_data_q[l]),
            .saturate (p2_q.saturate),
            .sum_c    (sum_c[l])
        );
    end

    assign result_c = p2_q.accumulate ? sum_c : p2_data_q;

    // Row storage: one write port shared by commit and clear, two read ports,
    // reads return the pre-write contents on a same-edge collision.
    always_ff @(posedge clk) begin
        if (enable) begin
            if (clr_we_c) begin
                mem[clr_cnt_q] <= '0;
            end else if (p3_valid_q) begin
                mem[p3_addr_q[ROW_W-1:0]] <= p3_data_q;
            end
            mem_acc_q <= mem[p1_q.addr[ROW_W-1:0]];
            rd_data_q <= mem[rd_addr_q];
        end
    end

    // Read path and drop pulse; out-of-range reads are forced to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q     <= '0;
            rd_ok_q       <= 1'b0;
            rd_ok2_q      <= 1'b0;
            data_out      <= '0;
            write_dropped <= 1'b0;
        end else if (enable) begin
            rd_addr_q     <= read_addr[ROW_W-1:0];
            rd_ok_q       <= (32'(read_addr) < REGISTER_DEPTH);
            rd_ok2_q      <= rd_ok_q;
            data_out      <= rd_ok2_q ? rd_data_q : '0;
            write_dropped <= wr_drop_c;
        end
    end

endmodule

// File: tb/tb_accumulator_file.sv
// Self-checking bench for accumulator_file: a vector table for the adder
// rules, directed sequences for clear/stall/reset corners, and a random run,
// all shadowed by a transaction-level model of rows and pending commits.
module tb_accumulator_file;
    import tpu_pkg::*;

    localparam int unsigned MW = 4;
    localparam int unsigned D  = 300;
    localparam int unsigned IW = $clog2(D);
    localparam accumulator_addr_type OOR = 10'h3FF;

    typedef logic [MW-1:0][31:0] row_t;

    logic                 clk = 1'b0;
    logic                 rst, enable, write_enable, accumulate, saturate, clear_start;
    logic                 busy, write_dropped;
    accumulator_addr_type write_addr, read_addr;
    row_t                 data_in, data_out;

    always #5 clk = ~clk;

    accumulator_file #(
        .MATRIX_WIDTH     (MW),
        .REGISTER_DEPTH   (D),
        .SATURATE_DEFAULT (1'b0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .write_addr    (write_addr),
        .data_in       (data_in),
        .write_enable  (write_enable),
        .accumulate    (accumulate),
        .saturate      (saturate),
        .read_addr     (read_addr),
        .data_out      (data_out),
        .clear_start   (clear_start),
        .busy          (busy),
        .write_dropped (write_dropped)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: committed rows, logical (all accepted writes) rows,
    // and a queue of writes waiting for their commit edge.
    typedef struct {
        int unsigned   due;
        logic [IW-1:0] row;
        row_t          val;
    } commit_t;

    row_t        mem_m  [D];
    row_t        shadow [D];
    commit_t     pend [$];
    int unsigned n = 0;
    logic        clearing = 1'b0;
    int unsigned clr_begin = 0;
    logic        busy_m = 1'b0, drop_m = 1'b0;
    row_t        dout_m = '0, rd_s1 = '0, rd_s2 = '0;

    function automatic row_t splat(logic [31:0] v);
        row_t r;
        for (int l = 0; l < MW; l++) r[l] = v;
        return r;
    endfunction

    function automatic row_t lane_add(row_t a, row_t b, logic sat);
        row_t        r;
        logic [32:0] s;
        for (int l = 0; l < MW; l++) begin
            s    = {1'b0, a[l]} + {1'b0, b[l]};
            r[l] = (sat && s[32]) ? 32'hFFFF_FFFF : s[31:0];
        end
        return r;
    endfunction

    task automatic apply_due();
        while (pend.size() > 0 && pend[0].due == n) begin
            mem_m[pend[0].row] = pend[0].val;
            void'(pend.pop_front());
        end
        if (clearing && n >= clr_begin + 4 && n <= clr_begin + 3 + D) begin
            mem_m[IW'(n - clr_begin - 4)]  = '0;
            shadow[IW'(n - clr_begin - 4)] = '0;
        end
    endtask

    task automatic model_edge();
        logic busy_prev;
        row_t v;
        if (rst) begin
            if (enable) begin
                n++;
                apply_due();
            end
            pend.delete();
            clearing = 1'b0;
            busy_m   = 1'b0;
            drop_m   = 1'b0;
            dout_m   = '0;
            rd_s1    = '0;
            rd_s2    = '0;
            for (int i = 0; i < D; i++) shadow[i] = mem_m[i];
            return;
        end
        if (!enable) return;
        n++;
        apply_due();
        busy_prev = busy_m;
        dout_m    = rd_s2;
        rd_s2     = rd_s1;
        rd_s1     = (32'(read_addr) < D) ? mem_m[read_addr[IW-1:0]] : '0;
        drop_m    = 1'b0;
        if (write_enable) begin
            if (busy_prev || 32'(write_addr) >= D) begin
                drop_m = 1'b1;
            end else begin
                v = accumulate ? lane_add(shadow[write_addr[IW-1:0]], data_in, saturate) : data_in;
                shadow[write_addr[IW-1:0]] = v;
                pend.push_back('{due: n + 3, row: write_addr[IW-1:0], val: v});
            end
        end
        if (clear_start && !busy_prev) begin
            clearing  = 1'b1;
            clr_begin = n;
        end
        busy_m = clearing && (n <= clr_begin + 2 + D);
        if (clearing && n >= clr_begin + 3 + D) clearing = 1'b0;
    endtask

    task automatic chk_bit(string name, logic act, logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_row(string name, row_t act, row_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs the DUT sampled, then check.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk_bit("busy", busy, busy_m);
        chk_bit("write_dropped", write_dropped, drop_m);
        chk_row("data_out", data_out, dout_m);
    endtask

    task automatic idle(int cycles);
        write_enable = 1'b0;
        clear_start  = 1'b0;
        enable       = 1'b1;
        read_addr    = OOR;
        repeat (cycles) tick();
    endtask

    task automatic wr(int unsigned row, row_t val, logic acc, logic sat);
        write_enable = 1'b1;
        write_addr   = 10'(row);
        data_in      = val;
        accumulate   = acc;
        saturate     = sat;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic read_expect(string name, int unsigned row, row_t exp);
        read_addr = 10'(row);
        tick();
        read_addr = OOR;
        tick();
        tick();
        chk_row(name, data_out, exp);
    endtask

    task automatic wait_not_busy(string name);
        int g = 0;
        while (busy === 1'b1 && g < 3 * D) begin
            tick();
            g++;
        end
        chk_bit(name, busy, 1'b0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] init;
        logic [31:0] add;
        logic        acc;
        logic        sat;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cycles;
        int g;

        vt[0] = '{"sat_clamp",      32'hFFFF_FFF0, 32'h20, 1'b1, 1'b1, 32'hFFFF_FFFF};
        vt[1] = '{"wrap",           32'hFFFF_FFF0, 32'h20, 1'b1, 1'b0, 32'h0000_0010};
        vt[2] = '{"small_add",      32'h0000_000A, 32'h01, 1'b1, 1'b0, 32'h0000_000B};
        vt[3] = '{"wrap_to_zero",   32'hFFFF_FFFF, 32'h01, 1'b1, 1'b0, 32'h0000_0000};
        vt[4] = '{"sat_no_carry",   32'h7FFF_FFFF, 32'h01, 1'b1, 1'b1, 32'h8000_0000};
        vt[5] = '{"sat_exact_max",  32'hFFFF_FFFE, 32'h01, 1'b1, 1'b1, 32'hFFFF_FFFF};
        vt[6] = '{"sat_big",        32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF};
        vt[7] = '{"overwrite_nsat", 32'h0000_0005, 32'h09, 1'b0, 1'b1, 32'h0000_0009};

        for (int i = 0; i < D; i++) begin
            mem_m[i]  = '0;
            shadow[i] = '0;
        end

        rst = 1'b1; enable = 1'b1; write_enable = 1'b0; accumulate = 1'b0;
        saturate = 1'b0; clear_start = 1'b0; write_addr = '0; read_addr = OOR;
        data_in = '0;
        tick();
        tick();
        chk_row("reset_data_out", data_out, '0);
        chk_bit("reset_busy", busy, 1'b0);
        chk_bit("reset_drop", write_dropped, 1'b0);
        rst = 1'b0;

        // Bring memory to a known state.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        wait_not_busy("init_clear_done");
        idle(2);

        // Overwrite then read with a gap.
        wr(5, splat(32'd7), 1'b0, 1'b0);
        idle(3);
        read_expect("row5_is_7", 5, splat(32'd7));

        // Overwrite followed by back-to-back accumulates.
        wr(3, splat(32'd10), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) wr(3, splat(32'd1), 1'b1, 1'b0);
        idle(3);
        read_expect("row3_burst_14", 3, splat(32'd14));

        // Adder rule table, accumulate issued right behind the overwrite.
        for (int i = 0; i < 8; i++) begin
            wr(2, splat(vt[i].init), 1'b0, 1'b0);
            wr(2, splat(vt[i].add), vt[i].acc, vt[i].sat);
            idle(3);
            read_expect(vt[i].name, 2, splat(vt[i].exp));
        end

        // Gap-1 and gap-2 accumulates to the same row.
        wr(4, splat(32'd100), 1'b0, 1'b0);
        idle(1);
        wr(4, splat(32'd5), 1'b1, 1'b0);
        idle(2);
        wr(4, splat(32'd6), 1'b1, 1'b0);
        idle(3);
        read_expect("row4_gaps_111", 4, splat(32'd111));

        // Accumulate burst with a 5-cycle stall in the middle.
        wr(4, splat(32'd100), 1'b0, 1'b0);
        wr(4, splat(32'd1), 1'b1, 1'b0);
        wr(4, splat(32'd2), 1'b1, 1'b0);
        write_enable = 1'b1; write_addr = 10'd4; data_in = splat(32'd50); accumulate = 1'b1;
        enable = 1'b0;
        repeat (5) tick();
        enable = 1'b1;
        write_enable = 1'b0;
        wr(4, splat(32'd3), 1'b1, 1'b0);
        wr(4, splat(32'd4), 1'b1, 1'b0);
        idle(3);
        read_expect("row4_stalled_110", 4, splat(32'd110));

        // Out-of-range write and read.
        wr(D, splat(32'hDEAD), 1'b0, 1'b0);
        chk_bit("oor_write_dropped", write_dropped, 1'b1);
        idle(3);
        wr(6, splat(32'h1234), 1'b0, 1'b0);
        idle(3);
        read_expect("oor_read_zero", D + 6, '0);

        // Fill, clear with a same-cycle write, probe drops, stall mid-clear.
        for (int r = 0; r < 8; r++) wr(r, splat(32'h100 + 32'(r)), 1'b0, 1'b0);
        clear_start = 1'b1; write_enable = 1'b1; write_addr = 10'd7;
        data_in = splat(32'd777); accumulate = 1'b0;
        tick();
        clear_start = 1'b0; write_enable = 1'b0;
        chk_bit("busy_after_clear_start", busy, 1'b1);
        busy_cycles = 1;
        g = 0;
        while (busy === 1'b1 && g < 3 * D) begin
            g++;
            write_enable = (g == 10);
            write_addr   = 10'd1;
            clear_start  = (g == 20);
            enable       = !(g >= 150 && g < 155);
            tick();
            if (g == 10) chk_bit("drop_while_busy", write_dropped, 1'b1);
            if (busy === 1'b1) busy_cycles++;
        end
        idle(1);
        chk_int("busy_cycles", busy_cycles, 3 + D + 5);
        for (int r = 0; r < 8; r++) read_expect("cleared_row", r, '0);

        // Reset while the clear counter is at 100.
        wr(50, splat(32'd5), 1'b0, 1'b0);
        wr(99, splat(32'd9), 1'b0, 1'b0);
        wr(150, splat(32'h1500), 1'b0, 1'b0);
        wr(200, splat(32'hABCD_0000), 1'b0, 1'b0);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        idle(103);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_bit("busy_after_rst", busy, 1'b0);
        for (int r = 0; r < 100; r++) read_expect("rst_clear_row", r, '0);
        read_expect("row150_kept", 150, splat(32'h1500));
        read_expect("row200_kept", 200, splat(32'hABCD_0000));

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            enable       = ($urandom_range(9) != 0);
            rst          = ($urandom_range(599) == 0);
            write_enable = $urandom_range(1);
            write_addr   = ($urandom_range(15) == 0) ? 10'(D + $urandom_range(7))
                                                      : 10'($urandom_range(5));
            accumulate   = ($urandom_range(3) != 0);
            saturate     = $urandom_range(1);
            for (int l = 0; l < MW; l++) begin
                data_in[l] = ($urandom_range(3) == 0) ? 32'hFFFF_FF00 + 32'($urandom_range(255))
                                                      : 32'($urandom_range(999));
            end
            read_addr    = ($urandom_range(7) == 0) ? OOR : 10'($urandom_range(5));
            clear_start  = ($urandom_range(299) == 0);
            tick();
        end
        rst = 1'b0;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
